// File: rtl/ps2_scancode_decoder_if.sv
// Key-event stream between the PS/2 scan-code decoder and its byte source / event consumer.
interface ps2_scancode_decoder_if #(
    parameter int FIFO_DEPTH = 8
);
    logic [7:0]                  code_byte;
    logic                        code_valid;
    logic                        ev_ready;
    logic                        ev_valid;
    logic [7:0]                  ev_code;
    logic                        ev_extended;
    logic                        ev_release;
    logic [$clog2(FIFO_DEPTH):0] ev_count;
    logic                        overflow;
    logic                        seq_err;

    modport master (
        output code_byte, code_valid, ev_ready,
        input  ev_valid, ev_code, ev_extended, ev_release, ev_count, overflow, seq_err
    );

    modport slave (
        input  code_byte, code_valid, ev_ready,
        output ev_valid, ev_code, ev_extended, ev_release, ev_count, overflow, seq_err
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Folds PS/2 set-2 prefix bytes (E0/F0/E1) into key events and queues them in a FWFT FIFO.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats of the held key.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    ps2_scancode_decoder_if.slave       bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

    state_t        state_r;
    logic [2:0]    skip_r;
    logic [TW-1:0] tmo_r;
    logic          seq_err_r;

    logic          bad_s;
    logic          push_s;
    logic          ev_push_s;
    logic [7:0]    push_code_s;
    logic          push_ext_s;
    logic          push_rel_s;

    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          overflow_r;
    logic          full_s;
    logic          pop_s;
    logic          wr_en_s;
    logic [9:0]    head_s;

    // Decode which byte completes an event and what that event is.
    always_comb begin
        push_s      = 1'b0;
        push_code_s = bus.code_byte;
        push_ext_s  = 1'b0;
        push_rel_s  = 1'b0;
        bad_s       = bus.code_valid && ((bus.code_byte == 8'h00) || (bus.code_byte == 8'hFF));
        if (bus.code_valid && !bad_s) begin
            case (state_r)
                IDLE: begin
                    case (bus.code_byte)
                        8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE: push_s = 1'b0;
                        default: push_s = 1'b1;
                    endcase
                end
                EXT: begin
                    push_s     = (bus.code_byte != 8'hF0);
                    push_ext_s = 1'b1;
                end
                BRK: begin
                    push_s     = 1'b1;
                    push_rel_s = 1'b1;
                end
                EXT_BRK: begin
                    push_s     = 1'b1;
                    push_ext_s = 1'b1;
                    push_rel_s = 1'b1;
                end
                PAUSE: begin
                    push_s      = (skip_r == 3'd1);
                    push_code_s = 8'hE1;
                end
                default: push_s = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_r;
    logic [7:0] held_code_r;
    logic       held_ext_r;
    logic       held_match_s;

    assign held_match_s = held_r && (held_code_r == push_code_s) && (held_ext_r == push_ext_s);
    // A make matching the held key is a typematic repeat and never reaches the FIFO.
    assign ev_push_s    = push_s && !(held_match_s && !push_rel_s);

    // Track the most recent make so repeats can be recognised; its release clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_r      <= 1'b0;
            held_code_r <= 8'h00;
            held_ext_r  <= 1'b0;
        end else if (push_s && !push_rel_s) begin
            held_r      <= 1'b1;
            held_code_r <= push_code_s;
            held_ext_r  <= push_ext_s;
        end else if (push_s && held_match_s) begin
            held_r      <= 1'b0;
        end
    end
`else
    assign ev_push_s = push_s;
`endif

    // Prefix-sequence FSM with inactivity timeout and registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            skip_r    <= 3'd0;
            tmo_r     <= '0;
            seq_err_r <= 1'b0;
        end else begin
            seq_err_r <= 1'b0;
            if (bus.code_valid) begin
                tmo_r <= '0;
                if (bad_s) begin
                    state_r   <= IDLE;
                    seq_err_r <= 1'b1;
                end else begin
                    case (state_r)
                        IDLE: begin
                            case (bus.code_byte)
                                8'hE0: state_r <= EXT;
                                8'hF0: state_r <= BRK;
                                8'hE1: begin
                                    state_r <= PAUSE;
                                    skip_r  <= 3'd7;
                                end
                                default: state_r <= IDLE;
                            endcase
                        end
                        EXT:     state_r <= (bus.code_byte == 8'hF0) ? EXT_BRK : IDLE;
                        BRK:     state_r <= IDLE;
                        EXT_BRK: state_r <= IDLE;
                        PAUSE: begin
                            skip_r <= skip_r - 3'd1;
                            if (skip_r == 3'd1) begin
                                state_r <= IDLE;
                            end
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end else if (state_r != IDLE) begin
                if (tmo_r == TMO_LAST) begin
                    state_r   <= IDLE;
                    seq_err_r <= 1'b1;
                    tmo_r     <= '0;
                end else begin
                    tmo_r <= tmo_r + TW'(1);
                end
            end else begin
                tmo_r <= '0;
            end
        end
    end

    assign full_s  = (count_r == (AW + 1)'(FIFO_DEPTH));
    assign pop_s   = (count_r != {(AW + 1){1'b0}}) && bus.ev_ready;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign wr_en_s = ev_push_s && (!full_s || pop_s);

    // Event FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 10'h000;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= {push_code_s, push_ext_s, push_rel_s};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
            if (ev_push_s && !wr_en_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign head_s          = mem_r[rd_ptr_r];
    assign bus.ev_valid    = (count_r != {(AW + 1){1'b0}});
    assign bus.ev_code     = head_s[9:2];
    assign bus.ev_extended = head_s[1];
    assign bus.ev_release  = head_s[0];
    assign bus.ev_count    = count_r;
    assign bus.overflow    = overflow_r;
    assign bus.seq_err     = seq_err_r;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: stimulus pushes expected events, a monitor pops on each accept.
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   seq_cnt  = 0;
    logic [9:0] exp_q [$];

    ps2_scancode_decoder_if #(.FIFO_DEPTH(DEPTH)) bus();

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head event is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.ev_valid && bus.ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event actual=%0h,%0b,%0b expected=none",
                         bus.ev_code, bus.ev_extended, bus.ev_release);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({bus.ev_code, bus.ev_extended, bus.ev_release} !== e) begin
                    failures++;
                    $display("FAIL event actual=%0h,%0b,%0b expected=%0h,%0b,%0b",
                             bus.ev_code, bus.ev_extended, bus.ev_release, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.seq_err) seq_cnt++;
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.code_byte  = b;
        bus.code_valid = 1'b1;
        @(posedge clk); #1;
        bus.code_valid = 1'b0;
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic x, input logic r);
        exp_q.push_back({c, x, r});
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.ev_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.ev_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_count"}, bus.ev_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [7:0] codes [9];
        codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};
        bus.code_byte  = 8'h00;
        bus.code_valid = 1'b0;
        bus.ev_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.ev_valid, 0);
        chk("rst_code", bus.ev_code, 0);
        chk("rst_ext_rel", {bus.ev_extended, bus.ev_release}, 0);
        chk("rst_count", bus.ev_count, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_seq_err", bus.seq_err, 0);

        // Single make: visible the cycle after the strobe, for exactly one cycle.
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        @(negedge clk);
        chk("lat_valid_n1", bus.ev_valid, 1);
        @(negedge clk);
        chk("lat_valid_n2", bus.ev_valid, 0);

        expect_ev(8'h75, 1'b1, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_ev(8'h1C, 1'b0, 1'b1);
        send(8'hF0); send(8'h1C);
        drain("ext_brk");

        s0 = seq_cnt;
        expect_ev(8'hE1, 1'b0, 1'b0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        drain("pause");
        chk("pause_no_seq_err", seq_cnt - s0, 0);

        s0 = seq_cnt;
        send(8'hE0);
        repeat (20) @(posedge clk);
        chk("timeout_seq_err", seq_cnt - s0, 1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        drain("after_timeout");

        s0 = seq_cnt;
        send(8'h00);
        send(8'hF0); send(8'hFF);
        send(8'hAA); send(8'hFA);
        repeat (3) @(posedge clk);
        chk("bad_byte_seq_err", seq_cnt - s0, 2);
        drain("bad_bytes");

        // Reset mid-sequence discards queued events and the pending prefix.
        bus.ev_ready = 1'b0;
        send(8'h2D); send(8'h2C); send(8'hE0);
        @(negedge clk);
        chk("pre_rst_count", bus.ev_count, 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", bus.ev_count, 0);
        chk("mid_rst_valid", bus.ev_valid, 0);
        bus.ev_ready = 1'b1;
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        drain("after_rst");

        bus.ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < DEPTH) expect_ev(codes[i], 1'b0, 1'b0);
            send(codes[i]);
        end
        @(negedge clk);
        chk("full_count", bus.ev_count, DEPTH);
        chk("overflow_set", bus.overflow, 1);
        @(posedge clk); #1;
        bus.ev_ready   = 1'b1;
        bus.code_byte  = 8'h46;
        bus.code_valid = 1'b1;
        expect_ev(8'h46, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.code_valid = 1'b0;
        bus.ev_ready   = 1'b0;
        @(negedge clk);
        chk("full_push_pop_count", bus.ev_count, DEPTH);
        drain("overflow");
        chk("overflow_sticky", bus.overflow, 1);

        expect_ev(8'h1C, 1'b0, 1'b0);
`ifndef PS2_TYPEMATIC_FILTER_EN
        expect_ev(8'h1C, 1'b0, 1'b0);
        expect_ev(8'h1C, 1'b0, 1'b0);
`endif
        expect_ev(8'h1C, 1'b0, 1'b1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
        @(negedge clk);
        drain("typematic");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 byte receiver.
- Consumes one scan-code-set-2 byte per strobe and folds the prefix bytes (E0 extended, F0 break, E1 pause) into complete key events.
- Queues each event in a small FIFO with a valid/ready output handshake, for use by display or UART logic.

Parameters:
- FIFO_DEPTH, 8, event queue depth; power of two, minimum 2.
- TIMEOUT_CYCLES, 100000, clk cycles a partial sequence may wait for its next byte before it is abandoned (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- code_byte  in  8  received scan byte.
- code_valid  in  1  one-cycle strobe, synchronous to clk; code_byte is sampled only when this is high.
- ev_ready  in  1  consumer accepts the head event.
- ev_valid  out  1  FIFO non-empty; head event is presented on the ev_* outputs.
- ev_code  out  8  final scan code of the event.
- ev_extended  out  1  event was prefixed by E0.
- ev_release  out  1  event was prefixed by F0 (key released).
- ev_count  out  clog2(FIFO_DEPTH)+1  current number of queued events.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- seq_err  out  1  one-cycle pulse on a timeout, or on receipt of byte 00 or FF.

Behaviour:
- Reset (asynchronous) values: FIFO empty, ev_valid=0, ev_code=00, ev_extended=0, ev_release=0, ev_count=0, overflow=0, seq_err=0; FSM in IDLE; timeout and skip counters cleared.
- Reset asserted mid-sequence discards the partial sequence and all queued events.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen), PAUSE (E1 seen).
- The FSM updates only on code_valid.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE, skip counter loaded with 7.
  - AA, FA, EE, FE -> stay in IDLE, no event.
  - 00 or FF -> seq_err pulse, stay in IDLE.
  - Any other byte -> push make event {code, ext=0, rel=0}.
- EXT transitions: F0 -> EXT_BRK; any other byte -> push {code, 1, 0} and go to IDLE.
- BRK: any byte -> push {code, 0, 1} and go to IDLE.
- EXT_BRK: any byte -> push {code, 1, 1} and go to IDLE.
- PAUSE: each byte decrements the skip counter. When it reaches 0, push {E1, 0, 0} and go to IDLE. The 8-byte pause sequence yields exactly one event.
- 00 or FF received in any non-IDLE state: seq_err pulse, go to IDLE, no event.
- Timeout counter:
  - Clears on every code_valid.
  - Counts only while the FSM is not in IDLE.
  - On reaching TIMEOUT_CYCLES-1: return to IDLE, seq_err pulse, no event.
- Latency: when the completing byte is strobed in cycle N, the event is written at the end of cycle N. If the FIFO was empty, ev_valid is high in cycle N+1 (first-word fall-through).
- Pop occurs when ev_valid && ev_ready. ev_* outputs must stay stable while ev_valid=1 and ev_ready=0.
- Push when FIFO not full: accepted.
- Push when FIFO full and no pop in the same cycle: event dropped, overflow set to 1 and held until reset.
- Push and pop in the same cycle when full: both happen; ev_count is unchanged.
- Push and pop in the same cycle when empty: not possible, since ev_valid=0.
- FIFO read and write pointers wrap modulo FIFO_DEPTH. ev_count is exact in the range 0..FIFO_DEPTH.

Optional Feature:
- Macro: PS2_TYPEMATIC_FILTER_EN.
- When defined: the decoder keeps a record of the last make event ({code, ext}) plus a held flag.
  - A make event that equals the held key is suppressed (typematic repeat), with no push.
  - A release event of the held key clears the held flag and is pushed normally.
  - A different make event replaces the held key and is pushed.
  - Reset clears the held flag.
- When undefined: every make byte, including repeats, produces an event.

Test Plan:
- Strobe 1C with ev_ready=1 -> one event {1C,0,0}; ev_valid high the cycle after the strobe, for one cycle.
- Strobe E0, F0, 75 -> exactly one event {75,1,1}. Strobe F0, 1C -> exactly one event {1C,0,1}.
- Strobe E1,14,77,E1,F0,14,F0,77 -> exactly one event {E1,0,0}; no seq_err.
- With TIMEOUT_CYCLES=16: strobe E0, then idle 20 cycles -> seq_err pulses once; a following 1C yields {1C,0,0}, not extended.
- With ev_ready=0 and FIFO_DEPTH=8: send 9 make codes -> ev_count=8 and overflow=1. Drain -> first 8 codes come out in order. Then push and pop in the same cycle while full -> ev_count stays 8.
- With PS2_TYPEMATIC_FILTER_EN defined: send 1C,1C,1C,F0,1C,1C -> events {1C,0,0}, {1C,0,1}, {1C,0,0}. Without the macro -> five events.
